// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder sequencer.
// master = producer/consumer side, slave = the sequencer.
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         busy;

    modport master (
        output in_valid, a_in, b_in, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum_out, cout_out, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, cin, op_sub, out_ready,
        output in_ready, out_valid, sum_out, cout_out, busy
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract built by walking one 4-bit ripple slice over NIBBLES cycles, LSB nibble first.
// States: IDLE accept operands | RUN one nibble per cycle | DONE hold result until out_ready.
module f_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sub_q;
    logic          carry;
    logic [IW-1:0] idx;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    slice_sum;
    logic          slice_cout;

    // Subtract is A + ~B + 1: the +1 enters through the preset carry register.
    assign a_nib = a_q[4*idx +: 4];
    assign b_nib = sub_q ? ~b_q[4*idx +: 4] : b_q[4*idx +: 4];

    f_adder4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            sub_q         <= 1'b0;
            carry         <= 1'b0;
            idx           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.sum_out   <= '0;
            bus.cout_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        a_q          <= bus.a_in;
                        b_q          <= bus.b_in;
                        sub_q        <= bus.op_sub;
                        carry        <= bus.op_sub | bus.cin;
                        idx          <= '0;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    bus.sum_out[4*idx +: 4] <= slice_sum;
                    carry                   <= slice_cout;
                    if (idx == LAST) begin
                        idx           <= '0;
                        bus.cout_out  <= slice_cout;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed cases, backpressure, mid-run reset, random ops,
// and a second 2-nibble instance, all checked against a plain-arithmetic reference.
module tb_nibble_serial_adder_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    nibble_serial_adder_ctrl_if #(.NIBBLES(4)) bi ();
    nibble_serial_adder_ctrl_if #(.NIBBLES(2)) bi2 ();

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bi)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bi2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result {cout, sum} from the arithmetic definition, not the slice structure.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic sub);
        int unsigned r;
        if (sub) return {(a >= b) ? 1'b1 : 1'b0, 16'(a - b)};
        r = 32'(a) + 32'(b) + 32'(c);
        return r[16:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string tag, output int cyc);
        cyc = 0;
        while (bi.out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check(tag, 64'(cyc), 64'd4);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic sub, input int stall, input bit early);
        logic [16:0] e;
        int          cyc;
        e = model(a, b, c, sub);
        check("idle_in_ready", 64'(bi.in_ready), 64'd1);
        bi.a_in = a; bi.b_in = b; bi.cin = c; bi.op_sub = sub;
        bi.in_valid  = 1'b1;
        bi.out_ready = early;
        tick();
        bi.in_valid = 1'($urandom_range(0, 1));
        bi.a_in     = 16'($urandom);
        bi.b_in     = 16'($urandom);
        bi.cin      = 1'($urandom_range(0, 1));
        bi.op_sub   = 1'($urandom_range(0, 1));
        check("run_busy", 64'(bi.busy), 64'd1);
        check("run_in_ready", 64'(bi.in_ready), 64'd0);
        wait_result("latency", cyc);
        check("sum", 64'(bi.sum_out), 64'(e[15:0]));
        check("cout", 64'(bi.cout_out), 64'(e[16]));
        for (int s = 0; s < stall; s++) begin
            bi.in_valid = 1'($urandom_range(0, 1));
            bi.a_in     = 16'($urandom);
            tick();
            check("stall_valid", 64'(bi.out_valid), 64'd1);
            check("stall_sum", 64'(bi.sum_out), 64'(e[15:0]));
            check("stall_cout", 64'(bi.cout_out), 64'(e[16]));
            check("stall_in_ready", 64'(bi.in_ready), 64'd0);
        end
        bi.out_ready = 1'b1;
        tick();
        bi.out_ready = 1'b0;
        bi.in_valid  = 1'b0;
        check("post_valid", 64'(bi.out_valid), 64'd0);
        check("post_in_ready", 64'(bi.in_ready), 64'd1);
        check("post_busy", 64'(bi.busy), 64'd0);
    endtask

    initial begin
        logic [16:0] e1;
        logic [16:0] e2;
        int          cyc;
        int          stall;
        bit          early;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bi.in_valid = 1'b0;  bi.a_in = '0;  bi.b_in = '0;  bi.cin = 1'b0;  bi.op_sub = 1'b0;
        bi.out_ready = 1'b0;
        bi2.in_valid = 1'b0; bi2.a_in = '0; bi2.b_in = '0; bi2.cin = 1'b0; bi2.op_sub = 1'b0;
        bi2.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 64'(bi.in_ready), 64'd1);
        check("rst_out_valid", 64'(bi.out_valid), 64'd0);
        check("rst_busy", 64'(bi.busy), 64'd0);
        check("rst_sum", 64'(bi.sum_out), 64'd0);
        check("rst_cout", 64'(bi.cout_out), 64'd0);

        // Directed known-answer cases
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
        check("kat_5555", 64'(bi.sum_out), 64'h5555);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        check("kat_ffff_1", 64'({bi.cout_out, bi.sum_out}), 64'h10000);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b1);
        check("kat_ffff_cin", 64'({bi.cout_out, bi.sum_out}), 64'h10000);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
        check("kat_sub_neg", 64'({bi.cout_out, bi.sum_out}), 64'h0FFFE);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0);
        check("kat_sub_pos", 64'({bi.cout_out, bi.sum_out}), 64'h10002);

        // Backpressure with new bundles offered throughout
        e1 = model(16'h0A0B, 16'h0102, 1'b1, 1'b0);
        e2 = model(16'h9000, 16'h8000, 1'b0, 1'b0);
        bi.a_in = 16'h0A0B; bi.b_in = 16'h0102; bi.cin = 1'b1; bi.op_sub = 1'b0;
        bi.in_valid = 1'b1;
        tick();
        wait_result("bp_latency", cyc);
        for (int s = 0; s < 5; s++) begin
            bi.in_valid = 1'b1;
            bi.a_in = 16'($urandom); bi.b_in = 16'($urandom);
            bi.op_sub = 1'($urandom_range(0, 1));
            tick();
            check("bp_sum", 64'(bi.sum_out), 64'(e1[15:0]));
            check("bp_cout", 64'(bi.cout_out), 64'(e1[16]));
            check("bp_in_ready", 64'(bi.in_ready), 64'd0);
            check("bp_valid", 64'(bi.out_valid), 64'd1);
        end
        bi.a_in = 16'h9000; bi.b_in = 16'h8000; bi.cin = 1'b0; bi.op_sub = 1'b0;
        bi.out_ready = 1'b1;
        tick();
        bi.out_ready = 1'b0;
        check("bp_hs_valid", 64'(bi.out_valid), 64'd0);
        check("bp_hs_no_accept", 64'(bi.busy), 64'd0);
        check("bp_hs_in_ready", 64'(bi.in_ready), 64'd1);
        tick();
        bi.in_valid = 1'b0;
        check("bp_second_accept", 64'(bi.busy), 64'd1);
        wait_result("bp2_latency", cyc);
        check("bp2_sum", 64'(bi.sum_out), 64'(e2[15:0]));
        check("bp2_cout", 64'(bi.cout_out), 64'(e2[16]));
        bi.out_ready = 1'b1;
        tick();
        bi.out_ready = 1'b0;

        // Reset while RUN is at nibble index 2
        bi.a_in = 16'h1234; bi.b_in = 16'h4321; bi.cin = 1'b0; bi.op_sub = 1'b0;
        bi.in_valid = 1'b1;
        tick();
        bi.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_in_ready", 64'(bi.in_ready), 64'd1);
        check("mrst_out_valid", 64'(bi.out_valid), 64'd0);
        check("mrst_sum", 64'(bi.sum_out), 64'd0);
        check("mrst_cout", 64'(bi.cout_out), 64'd0);
        check("mrst_busy", 64'(bi.busy), 64'd0);
        for (int s = 0; s < 6; s++) begin
            tick();
            check("mrst_no_result", 64'(bi.out_valid), 64'd0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        check("mrst_after", 64'(bi.sum_out), 64'h0002);

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            stall = int'($urandom_range(0, 3));
            early = (stall == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), stall, early);
        end

        // 2-nibble instance
        check("n2_in_ready", 64'(bi2.in_ready), 64'd1);
        bi2.a_in = 8'h80; bi2.b_in = 8'h80; bi2.cin = 1'b0; bi2.op_sub = 1'b0;
        bi2.in_valid = 1'b1;
        tick();
        bi2.in_valid = 1'b0;
        cyc = 0;
        while (bi2.out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("n2_latency", 64'(cyc), 64'd2);
        check("n2_sum", 64'(bi2.sum_out), 64'h00);
        check("n2_cout", 64'(bi2.cout_out), 64'd1);
        bi2.out_ready = 1'b1;
        tick();
        bi2.out_ready = 1'b0;
        check("n2_post_in_ready", 64'(bi2.in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs wide add/subtract by time-multiplexing one existing 4-bit ripple adder slice (f_adder4) over NIBBLES cycles, least-significant nibble first.
- Adds a registered carry chain between nibbles plus valid/ready handshakes on the operand and result sides.
- Sits between an operand producer and a result consumer where area matters more than latency.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept an operand bundle.
- a_in  input  W  operand A.
- b_in  input  W  operand B.
- cin  input  1  carry-in for an add; ignored when op_sub=1.
- op_sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum_out  output  W  result.
- cout_out  output  1  final carry out; for a subtract, 1 means no borrow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset values: in_ready=1, out_valid=0, busy=0, sum_out=0, cout_out=0, internal nibble index=0, carry register=0; state=IDLE.
- Datapath: one f_adder4 instance.
  - Operand nibbles are selected by the nibble index from registered copies of A and B.
  - For a subtract, the B nibble is inverted before it reaches the slice.
  - Slice cin comes from the carry register.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, capture a_in, b_in and op_sub.
  - Carry register <= (op_sub ? 1 : cin); index <= 0; go to RUN.
  - Inputs are not sampled again until the block returns to IDLE.
- RUN:
  - in_ready=0.
  - Each cycle, write the slice sum into sum_out[4*idx+3:4*idx] and write the slice cout into the carry register.
  - idx increments each cycle.
  - On the cycle where idx == NIBBLES-1: cout_out <= slice cout, go to DONE.
  - RUN lasts exactly NIBBLES cycles.
- DONE:
  - out_valid=1.
  - sum_out and cout_out stay stable while out_valid=1 && out_ready=0; backpressure can last any length of time.
  - On out_ready=1: out_valid <= 0, go to IDLE, in_ready <= 1 on the next cycle.
  - There is no bypass: a new bundle cannot be accepted in the same cycle as the result handshake.
- Latency: accept at edge T; out_valid is first high after edge T+NIBBLES. Throughput is one operation per NIBBLES+2 cycles with out_ready tied high.
- sum_out nibbles above the current idx hold stale values during RUN. Only values qualified by out_valid are defined.
- in_valid in RUN or DONE is ignored and does not queue.
- op_sub/cin changes after capture have no effect.
- Arithmetic is modulo 2^W. No overflow flag; signed overflow is the consumer's job.
- rst asserted in any state, including mid-RUN or while DONE is stalled:
  - All outputs return to their reset values on the next edge.
  - The partial result is discarded and no out_valid is produced for it.
- out_ready asserted outside DONE has no effect.

Test Plan:
- NIBBLES=4, A=0x1234, B=0x4321, cin=0, op_sub=0 -> out_valid high exactly 4 cycles after accept; sum_out=0x5555, cout_out=0.
- A=0xFFFF, B=0x0001, cin=0 (carry ripples through every nibble via the carry register) -> sum_out=0x0000, cout_out=1. Repeat with A=0xFFFF, B=0x0000, cin=1 -> sum_out=0x0000, cout_out=1.
- op_sub=1, A=0x0005, B=0x0007, cin=1 (must be ignored) -> sum_out=0xFFFE, cout_out=0. Then A=0x0007, B=0x0005 -> sum_out=0x0002, cout_out=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 and new operands applied throughout -> sum_out/cout_out stable; in_ready=0; the second bundle is accepted only the cycle after the out_ready handshake, and its result is correct.
- Reset mid-RUN (rst pulsed at idx=2 of 0x1234+0x4321) -> next cycle in_ready=1, out_valid=0, sum_out=0, cout_out=0, busy=0. A following 0x0001+0x0001 yields 0x0002.
- NIBBLES=2 build: A=0x80, B=0x80 -> sum_out=0x00, cout_out=1, latency 2 cycles.
